// File: rtl/fetch_pkg.sv
// Shared types and sizing for the decoupled fetch stage (fetch_q).
package fetch_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned ILEN        = 32;
    localparam int unsigned QDEPTH_DEF  = 4;
    localparam int unsigned MAX_OUT_DEF = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return unsigned'($clog2(n + 1));
    endfunction

    localparam int unsigned QCNT_W = cnt_w(QDEPTH_DEF);
    localparam int unsigned OCNT_W = cnt_w(MAX_OUT_DEF);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic [ILEN-1:0] ir;
    } fe_entry_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/fetch_q_if.sv
// Instruction-cache request/response channel and decode handshake of the fetch stage.
interface fetch_q_if;

    logic                          IC_REQ_V;
    logic                          IC_REQ_RDY;
    logic [fetch_pkg::XLEN-1:0]    IC_REQ_ADDR;
    logic                          IC_RSP_V;
    logic [fetch_pkg::ILEN-1:0]    IC_RSP_INSTR;
    logic                          DE_READY;
    logic                          DE_V;
    logic [fetch_pkg::XLEN-1:0]    DE_PC;
    logic [fetch_pkg::XLEN-1:0]    DE_NPC;
    logic [fetch_pkg::ILEN-1:0]    DE_IR;

    modport master (
        output IC_REQ_V, IC_REQ_ADDR, DE_V, DE_PC, DE_NPC, DE_IR,
        input  IC_REQ_RDY, IC_RSP_V, IC_RSP_INSTR, DE_READY
    );

    modport slave (
        input  IC_REQ_V, IC_REQ_ADDR, DE_V, DE_PC, DE_NPC, DE_IR,
        output IC_REQ_RDY, IC_RSP_V, IC_RSP_INSTR, DE_READY
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched entries; flush clears it and wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = QDEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fe_entry_t                    din,
    output fe_entry_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fe_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   rd_q, wr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               do_pop;

    assign do_pop = pop && (cnt_q != '0);
    assign count  = cnt_q;
    // Empty queue presents an all-zero head.
    assign head   = (cnt_q != '0) ? mem[rd_q] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem[wr_q] <= din;
                wr_q      <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_q.sv
// Decoupled fetch: sequential I-cache requests, in-order responses, instruction queue to decode.
// Define FETCH_PERF_CNT_EN to build the saturating fetched/flushed performance counters.
module fetch_q
    import fetch_pkg::*;
#(
    parameter int unsigned     QDEPTH   = QDEPTH_DEF,
    parameter int unsigned     MAX_OUT  = MAX_OUT_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FE_PC_MUX,
    input  logic [XLEN-1:0] FE_TARGET_ADDRESS,
    input  logic            BR_STALL,
    fetch_q_if.master       bus,
    output logic [31:0]     PERF_FETCHED,
    output logic [31:0]     PERF_FLUSHED
);
    localparam int unsigned QC_W = cnt_w(QDEPTH);
    localparam int unsigned OC_W = cnt_w(MAX_OUT);

    logic [XLEN-1:0] fpc_q, fpc_d, rpc_q, rpc_d;
    logic [OC_W-1:0] out_q, out_d, drop_q, drop_d;
    logic [QC_W-1:0] q_cnt;
    logic            issue, fire, push, pop, rsp_drop;
    fe_entry_t       head, push_entry;

    fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .flush (FE_PC_MUX),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .head  (head),
        .count (q_cnt)
    );

    // Issue only while every live request still has a reserved queue slot.
    assign issue = !RESET && !FE_PC_MUX && !BR_STALL
                && (32'(out_q) < 32'(MAX_OUT))
                && (32'(q_cnt) + 32'(out_q) - 32'(drop_q) < 32'(QDEPTH));
    assign fire     = issue && bus.IC_REQ_RDY;
    assign rsp_drop = bus.IC_RSP_V && (drop_q != '0);
    assign push     = bus.IC_RSP_V && (drop_q == '0) && !FE_PC_MUX;
    assign pop      = (q_cnt != '0) && bus.DE_READY;

    assign push_entry = '{pc: rpc_q, npc: rpc_q + XLEN'(4), ir: bus.IC_RSP_INSTR};

    assign bus.IC_REQ_V    = issue;
    assign bus.IC_REQ_ADDR = fpc_q;
    assign bus.DE_V        = (q_cnt != '0);
    assign bus.DE_PC       = head.pc;
    assign bus.DE_NPC      = head.npc;
    assign bus.DE_IR       = head.ir;

    // Redirect overrides both PCs and marks every surviving in-flight request as stale.
    always_comb begin
        fpc_d  = fpc_q;
        rpc_d  = rpc_q;
        drop_d = drop_q;
        out_d  = out_q + OC_W'(fire) - OC_W'(bus.IC_RSP_V);
        if (fire) begin
            fpc_d = fpc_q + XLEN'(4);
        end
        if (push) begin
            rpc_d = rpc_q + XLEN'(4);
        end
        if (rsp_drop) begin
            drop_d = drop_q - OC_W'(1);
        end
        if (FE_PC_MUX) begin
            fpc_d  = FE_TARGET_ADDRESS;
            rpc_d  = FE_TARGET_ADDRESS;
            drop_d = out_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fpc_q  <= RESET_PC;
            rpc_q  <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            fpc_q  <= fpc_d;
            rpc_q  <= rpc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, flushed_q, flush_inc;

    always_comb begin
        flush_inc = '0;
        if (FE_PC_MUX) begin
            flush_inc = 32'(q_cnt) + 32'(bus.IC_RSP_V);
        end else if (rsp_drop) begin
            flush_inc = 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (push) begin
                fetched_q <= sat_add(fetched_q, 32'd1);
            end
            flushed_q <= sat_add(flushed_q, flush_inc);
        end
    end

    assign PERF_FETCHED = fetched_q;
    assign PERF_FLUSHED = flushed_q;
`else
    assign PERF_FETCHED = '0;
    assign PERF_FLUSHED = '0;
`endif

endmodule

// File: tb/tb_fetch_q.sv
// Directed bench for fetch_q: per-cycle vector table plus redirect/wrap/ready-stall sequences.
module tb_fetch_q;
    import fetch_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FE_PC_MUX = 1'b0;
    logic [63:0] FE_TARGET_ADDRESS = '0;
    logic        BR_STALL = 1'b0;
    logic [31:0] PERF_FETCHED, PERF_FLUSHED;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned lat     = 1;

    fetch_q_if bus();

    fetch_q #(.QDEPTH(4), .MAX_OUT(2), .RESET_PC(64'h0)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .FE_PC_MUX         (FE_PC_MUX),
        .FE_TARGET_ADDRESS (FE_TARGET_ADDRESS),
        .BR_STALL          (BR_STALL),
        .bus               (bus),
        .PERF_FETCHED      (PERF_FETCHED),
        .PERF_FLUSHED      (PERF_FLUSHED)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    // In-order cache model with fixed latency `lat`, reset together with the DUT.
    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] due;
    } pend_t;
    pend_t pend[$];

    always @(negedge CLK) begin
        pend_t p;
        if (RESET) begin
            pend.delete();
        end else begin
            if (bus.IC_RSP_V && pend.size() > 0) void'(pend.pop_front());
            if (bus.IC_REQ_V && bus.IC_REQ_RDY) begin
                p.addr = bus.IC_REQ_ADDR;
                p.due  = cyc + lat;
                pend.push_back(p);
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        if (!RESET && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.IC_RSP_V     = 1'b1;
            bus.IC_RSP_INSTR = instr_of(pend[0].addr);
        end else begin
            bus.IC_RSP_V     = 1'b0;
            bus.IC_RSP_INSTR = '0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Sample one cycle's outputs at the falling edge, then step to the next cycle.
    task automatic expect_cycle(input string tag, input logic dv, input logic [63:0] pc,
                                input logic rv, input logic [63:0] ra);
        @(negedge CLK);
        chk({tag, " DE_V"}, 64'(bus.DE_V), 64'(dv));
        if (dv) begin
            chk({tag, " DE_PC"}, bus.DE_PC, pc);
            chk({tag, " DE_NPC"}, bus.DE_NPC, pc + 64'd4);
            chk({tag, " DE_IR"}, 64'(bus.DE_IR), 64'(instr_of(pc)));
        end
        chk({tag, " IC_REQ_V"}, 64'(bus.IC_REQ_V), 64'(rv));
        if (rv) chk({tag, " IC_REQ_ADDR"}, bus.IC_REQ_ADDR, ra);
        next_cycle();
    endtask

    task automatic restart(input int unsigned l);
        RESET = 1'b1;
        FE_PC_MUX = 1'b0;
        BR_STALL = 1'b0;
        bus.DE_READY = 1'b1;
        bus.IC_REQ_RDY = 1'b1;
        lat = l;
        repeat (2) next_cycle();
        RESET = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic        stall;
        logic        dv;
        logic [63:0] pc;
        logic        rv;
        logic [63:0] ra;
    } vec_t;

    function automatic vec_t mkv(input logic rdy, input logic stall, input logic dv,
                                 input logic [63:0] pc, input logic rv, input logic [63:0] ra);
        vec_t v;
        v.rdy = rdy; v.stall = stall; v.dv = dv; v.pc = pc; v.rv = rv; v.ra = ra;
        return v;
    endfunction

    localparam int NV = 31;
    vec_t vec [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.IC_RSP_V = 1'b0;
        bus.IC_RSP_INSTR = '0;
        bus.IC_REQ_RDY = 1'b1;
        bus.DE_READY = 1'b1;

        // Single-cycle cache: free run, 10-cycle decode stall, 5-cycle branch stall.
        vec[0]  = mkv(1, 0, 0, 0,  1, 0);
        vec[1]  = mkv(1, 0, 0, 0,  1, 4);
        vec[2]  = mkv(1, 0, 1, 0,  1, 8);
        vec[3]  = mkv(1, 0, 1, 4,  1, 12);
        vec[4]  = mkv(1, 0, 1, 8,  1, 16);
        vec[5]  = mkv(1, 0, 1, 12, 1, 20);
        vec[6]  = mkv(0, 0, 1, 16, 1, 24);
        vec[7]  = mkv(0, 0, 1, 16, 1, 28);
        for (int i = 8; i <= 15; i++) vec[i] = mkv(0, 0, 1, 16, 0, 0);
        vec[16] = mkv(1, 0, 1, 16, 0, 0);
        vec[17] = mkv(1, 0, 1, 20, 1, 32);
        vec[18] = mkv(1, 0, 1, 24, 1, 36);
        vec[19] = mkv(1, 0, 1, 28, 1, 40);
        vec[20] = mkv(1, 0, 1, 32, 1, 44);
        vec[21] = mkv(1, 0, 1, 36, 1, 48);
        vec[22] = mkv(1, 1, 1, 40, 0, 0);
        vec[23] = mkv(1, 1, 1, 44, 0, 0);
        vec[24] = mkv(1, 1, 1, 48, 0, 0);
        vec[25] = mkv(1, 1, 0, 0,  0, 0);
        vec[26] = mkv(1, 1, 0, 0,  0, 0);
        vec[27] = mkv(1, 0, 0, 0,  1, 52);
        vec[28] = mkv(1, 0, 0, 0,  1, 56);
        vec[29] = mkv(1, 0, 1, 52, 1, 60);
        vec[30] = mkv(1, 0, 1, 56, 1, 64);

        // Reset values.
        RESET = 1'b1;
        lat = 1;
        @(negedge CLK);
        chk("reset DE_V", 64'(bus.DE_V), 64'd0);
        chk("reset DE_PC", bus.DE_PC, 64'd0);
        chk("reset DE_NPC", bus.DE_NPC, 64'd0);
        chk("reset DE_IR", 64'(bus.DE_IR), 64'd0);
        chk("reset IC_REQ_V", 64'(bus.IC_REQ_V), 64'd0);
        chk("reset PERF_FETCHED", 64'(PERF_FETCHED), 64'd0);
        chk("reset PERF_FLUSHED", 64'(PERF_FLUSHED), 64'd0);
        next_cycle();
        RESET = 1'b0;

        for (int i = 0; i < NV; i++) begin
            bus.DE_READY = vec[i].rdy;
            BR_STALL = vec[i].stall;
            expect_cycle($sformatf("vec%0d", i), vec[i].dv, vec[i].pc, vec[i].rv, vec[i].ra);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("stream PERF_FETCHED", 64'(PERF_FETCHED), 64'd16);
        chk("stream PERF_FLUSHED", 64'(PERF_FLUSHED), 64'd0);
`else
        chk("stream PERF_FETCHED tied", 64'(PERF_FETCHED), 64'd0);
        chk("stream PERF_FLUSHED tied", 64'(PERF_FLUSHED), 64'd0);
`endif

        // Redirect with two requests in flight on a 3-cycle cache (reset mid-operation first).
        restart(3);
        expect_cycle("redirA c0", 0, 0, 1, 64'h0);
        expect_cycle("redirA c1", 0, 0, 1, 64'h4);
        FE_PC_MUX = 1'b1;
        FE_TARGET_ADDRESS = 64'h1000;
        expect_cycle("redirA c2", 0, 0, 0, 0);
        FE_PC_MUX = 1'b0;
        expect_cycle("redirA c3", 0, 0, 0, 0);
        expect_cycle("redirA c4", 0, 0, 1, 64'h1000);
        expect_cycle("redirA c5", 0, 0, 1, 64'h1004);
        expect_cycle("redirA c6", 0, 0, 0, 0);
        expect_cycle("redirA c7", 0, 0, 0, 0);
        expect_cycle("redirA c8", 1, 64'h1000, 1, 64'h1008);
        expect_cycle("redirA c9", 1, 64'h1004, 1, 64'h100C);
`ifdef FETCH_PERF_CNT_EN
        chk("redirA PERF_FLUSHED", 64'(PERF_FLUSHED), 64'd2);
        chk("redirA PERF_FETCHED", 64'(PERF_FETCHED), 64'd2);
`endif

        // Redirect, response and pop in the same cycle.
        restart(1);
        expect_cycle("redirB c0", 0, 0, 1, 64'h0);
        expect_cycle("redirB c1", 0, 0, 1, 64'h4);
        FE_PC_MUX = 1'b1;
        FE_TARGET_ADDRESS = 64'h2000;
        expect_cycle("redirB c2", 1, 64'h0, 0, 0);
        FE_PC_MUX = 1'b0;
        expect_cycle("redirB c3", 0, 0, 1, 64'h2000);
        expect_cycle("redirB c4", 0, 0, 1, 64'h2004);
        expect_cycle("redirB c5", 1, 64'h2000, 1, 64'h2008);
`ifdef FETCH_PERF_CNT_EN
        chk("redirB PERF_FLUSHED", 64'(PERF_FLUSHED), 64'd2);
        chk("redirB PERF_FETCHED", 64'(PERF_FETCHED), 64'd3);
`endif

        // PC wrap at the top of the address space, then a cache back-pressure cycle.
        restart(1);
        FE_PC_MUX = 1'b1;
        FE_TARGET_ADDRESS = 64'hFFFF_FFFF_FFFF_FFFC;
        expect_cycle("wrap c0", 0, 0, 0, 0);
        FE_PC_MUX = 1'b0;
        expect_cycle("wrap c1", 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        expect_cycle("wrap c2", 0, 0, 1, 64'h0);
        expect_cycle("wrap c3", 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h4);
        expect_cycle("wrap c4", 1, 64'h0, 1, 64'h8);
        bus.IC_REQ_RDY = 1'b0;
        expect_cycle("wrap c5", 1, 64'h4, 1, 64'hC);
        bus.IC_REQ_RDY = 1'b1;
        expect_cycle("wrap c6", 1, 64'h8, 1, 64'hC);
        expect_cycle("wrap c7", 0, 0, 1, 64'h10);
        expect_cycle("wrap c8", 1, 64'hC, 1, 64'h14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
